// File: rtl/delay_sum_beamformer_if.sv
// Frame/result bus of the delay-and-sum beamformer: frame samples and delay
// requests towards the beamformer, beam sample and status flags back.
interface delay_sum_beamformer_if #(
  parameter int BIT_WIDTH = 24,
  parameter int SLOTS     = 4,
  parameter int MAX_DELAY = 32
);
  localparam int DELAY_WIDTH = $clog2(MAX_DELAY);
  localparam int SUM_WIDTH   = BIT_WIDTH + $clog2(SLOTS);

  logic signed [BIT_WIDTH-1:0] audio_in [SLOTS];
  logic                        audio_valid_in;
  logic [DELAY_WIDTH-1:0]      delay_in [SLOTS];
  logic                        delay_load_in;
  logic signed [SUM_WIDTH-1:0] sum_out;
  logic                        sum_valid_out;
  logic                        overrun_out;
  logic                        busy_out;

  modport master (
    output audio_in, audio_valid_in, delay_in, delay_load_in,
    input  sum_out, sum_valid_out, overrun_out, busy_out
  );

  modport slave (
    input  audio_in, audio_valid_in, delay_in, delay_load_in,
    output sum_out, sum_valid_out, overrun_out, busy_out
  );
endinterface

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel circular frame history, programmable
// per-channel frame delay, one full-precision signed beam sample per frame.
module delay_sum_beamformer #(
  parameter int BIT_WIDTH = 24,
  parameter int SLOTS     = 4,
  parameter int MAX_DELAY = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  delay_sum_beamformer_if.slave bus
);
  localparam int DELAY_WIDTH = $clog2(MAX_DELAY);
  localparam int IDX_WIDTH   = $clog2(SLOTS);
  localparam int SUM_WIDTH   = BIT_WIDTH + IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_next_s;
  logic                        accept_s;
  logic                        accum_s;
  logic                        done_s;
  logic                        overrun_s;
  logic                        load_now_s;
  logic                        load_defer_s;
  logic                        apply_pending_s;

  logic signed [BIT_WIDTH-1:0] hist_r [SLOTS][MAX_DELAY];
  logic [DELAY_WIDTH-1:0]      wr_ptr_r;
  logic [DELAY_WIDTH-1:0]      rd_ptr_s;
  logic [DELAY_WIDTH-1:0]      delay_r [SLOTS];
  logic [DELAY_WIDTH-1:0]      pending_r [SLOTS];
  logic                        pending_valid_r;
  logic [IDX_WIDTH-1:0]        idx_r;
  logic signed [BIT_WIDTH-1:0] rd_sample_s;
  logic signed [SUM_WIDTH-1:0] acc_r;
  logic signed [SUM_WIDTH-1:0] sum_r;
  logic                        sum_valid_r;
  logic                        overrun_r;
  logic                        busy_r;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    accum_s      = 1'b0;
    done_s       = 1'b0;
    overrun_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.audio_valid_in) begin
          accept_s     = 1'b1;
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        accum_s   = 1'b1;
        overrun_s = bus.audio_valid_in;
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        done_s       = 1'b1;
        overrun_s    = bus.audio_valid_in;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Delay-load arbitration: a request that coincides with a frame or arrives
  // mid-frame is parked so the frame in flight keeps one delay set throughout.
  always_comb begin
    load_now_s      = (state_r == ST_IDLE) && bus.delay_load_in && !bus.audio_valid_in;
    load_defer_s    = bus.delay_load_in && !load_now_s;
    apply_pending_s = (state_r == ST_IDLE) && pending_valid_r && !load_now_s;
  end

  // Active and pending delay sets.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SLOTS; i++) begin
        delay_r[i]   <= {DELAY_WIDTH{1'b0}};
        pending_r[i] <= {DELAY_WIDTH{1'b0}};
      end
      pending_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (load_now_s) begin
          delay_r[i] <= bus.delay_in[i];
        end else if (apply_pending_s) begin
          delay_r[i] <= pending_r[i];
        end
        if (load_defer_s) begin
          pending_r[i] <= bus.delay_in[i];
        end
      end
      if (load_defer_s) begin
        pending_valid_r <= 1'b1;
      end else if (apply_pending_s || load_now_s) begin
        pending_valid_r <= 1'b0;
      end
    end
  end

  // Per-channel circular history, written once per accepted frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SLOTS; i++) begin
        for (int j = 0; j < MAX_DELAY; j++) begin
          hist_r[i][j] <= {BIT_WIDTH{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int i = 0; i < SLOTS; i++) begin
        hist_r[i][wr_ptr_r] <= bus.audio_in[i];
      end
    end
  end

  // Tap select; the pointer difference wraps naturally at MAX_DELAY.
  always_comb begin
    rd_ptr_s    = wr_ptr_r - delay_r[idx_r];
    rd_sample_s = hist_r[idx_r][rd_ptr_s];
  end

  // Accumulator, channel index and write pointer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_r    <= {SUM_WIDTH{1'b0}};
      idx_r    <= {IDX_WIDTH{1'b0}};
      wr_ptr_r <= {DELAY_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        acc_r <= {SUM_WIDTH{1'b0}};
        idx_r <= {IDX_WIDTH{1'b0}};
      end else if (accum_s) begin
        acc_r <= acc_r + {{(SUM_WIDTH - BIT_WIDTH){rd_sample_s[BIT_WIDTH-1]}}, rd_sample_s};
        idx_r <= idx_r + IDX_WIDTH'(1);
      end
      if (done_s) begin
        wr_ptr_r <= wr_ptr_r + DELAY_WIDTH'(1);
      end
    end
  end

  // Registered outputs; busy also covers the cycle in which sum_valid is high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_r       <= {SUM_WIDTH{1'b0}};
      sum_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (done_s) begin
        sum_r <= acc_r;
      end
      sum_valid_r <= done_s;
      overrun_r   <= overrun_s;
      busy_r      <= (state_next_s != ST_IDLE) || done_s;
    end
  end

  assign bus.sum_out       = sum_r;
  assign bus.sum_valid_out = sum_valid_r;
  assign bus.overrun_out   = overrun_r;
  assign bus.busy_out      = busy_r;
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer: hand-computed beam sums, latency,
// overrun, delay-load timing and mid-frame reset.
module tb_delay_sum_beamformer;
  localparam int BW = 24;
  localparam int SL = 4;
  localparam int MD = 32;

  logic        clk_in = 1'b0;
  logic        rst_in;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          ov_cnt = 0;
  int          mid_vld;
  logic [25:0] raw_sum;

  always #5 clk_in = ~clk_in;

  delay_sum_beamformer_if #(.BIT_WIDTH(BW), .SLOTS(SL), .MAX_DELAY(MD)) bus ();

  delay_sum_beamformer #(.BIT_WIDTH(BW), .SLOTS(SL), .MAX_DELAY(MD)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always @(negedge clk_in) begin
    if (bus.overrun_out === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_audio(input int a0, input int a1, input int a2, input int a3);
    bus.audio_in[0] = BW'(a0);
    bus.audio_in[1] = BW'(a1);
    bus.audio_in[2] = BW'(a2);
    bus.audio_in[3] = BW'(a3);
  endtask

  task automatic set_delay(input int d0, input int d1, input int d2, input int d3);
    bus.delay_in[0] = 5'(d0);
    bus.delay_in[1] = 5'(d1);
    bus.delay_in[2] = 5'(d2);
    bus.delay_in[3] = 5'(d3);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic load_delays(input int d0, input int d1, input int d2, input int d3);
    @(negedge clk_in);
    set_delay(d0, d1, d2, d3);
    bus.delay_load_in = 1'b1;
    @(negedge clk_in);
    bus.delay_load_in = 1'b0;
  endtask

  // Strobe driven at negedge N0 is sampled at edge 0; the result registered at
  // edge 5 is first visible at negedge N6. load_at/dup_at pulse delay_load_in or
  // a second strobe so that it is sampled at that edge number (-1 = never).
  task automatic run_frame(input string tag, input int a0, input int a1, input int a2,
                           input int a3, input longint exp, input int load_at,
                           input int load_d, input int dup_at);
    int lat;
    int vcnt;
    lat  = -1;
    vcnt = 0;
    @(negedge clk_in);
    set_audio(a0, a1, a2, a3);
    bus.audio_valid_in = 1'b1;
    bus.delay_load_in  = (load_at == 0);
    if (load_at == 0) set_delay(load_d, load_d, load_d, load_d);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_in);
      if (bus.sum_valid_out === 1'b1) begin
        vcnt++;
        if (lat < 0) lat = k;
      end
      if (k == 1) check_eq({tag, "_busy"}, bus.busy_out, 64'sd1);
      if (k == 7) check_eq({tag, "_idle"}, bus.busy_out, 64'sd0);
      bus.audio_valid_in = (k == dup_at);
      if (k == dup_at) set_audio(50, 50, 50, 50);
      bus.delay_load_in = (k == load_at);
      if (k == load_at) set_delay(load_d, load_d, load_d, load_d);
    end
    check_eq({tag, "_lat"}, lat, 64'sd6);
    check_eq({tag, "_nvld"}, vcnt, 64'sd1);
    check_eq({tag, "_sum"}, bus.sum_out, exp);
  endtask

  initial begin
    rst_in             = 1'b1;
    bus.audio_valid_in = 1'b0;
    bus.delay_load_in  = 1'b0;
    set_audio(0, 0, 0, 0);
    set_delay(0, 0, 0, 0);
    repeat (3) @(negedge clk_in);
    check_eq("rst_sum", bus.sum_out, 64'sd0);
    check_eq("rst_vld", bus.sum_valid_out, 64'sd0);
    check_eq("rst_ovr", bus.overrun_out, 64'sd0);
    check_eq("rst_busy", bus.busy_out, 64'sd0);
    rst_in = 1'b0;

    run_frame("basic", 1, 2, 3, 4, 10, -1, 0, -1);
    check_eq("basic_ovr", ov_cnt, 64'sd0);

    run_frame("neg", -8388608, -8388608, -8388608, -8388608, -33554432, -1, 0, -1);
    raw_sum = bus.sum_out;
    check_eq("neg_bits", raw_sum, 64'h2000000);

    // Impulse on channel 1 with a 3-frame delay.
    do_reset();
    load_delays(0, 3, 0, 0);
    run_frame("imp0", 0, 100, 0, 0, 0, -1, 0, -1);
    run_frame("imp1", 0, 0, 0, 0, 0, -1, 0, -1);
    run_frame("imp2", 0, 0, 0, 0, 0, -1, 0, -1);
    run_frame("imp3", 0, 0, 0, 0, 100, -1, 0, -1);
    run_frame("imp4", 0, 0, 0, 0, 0, -1, 0, -1);

    // Maximum delay across the history wrap.
    do_reset();
    load_delays(31, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      run_frame($sformatf("wrap%0d", n), n, 0, 0, 0, (n >= 31) ? longint'(n - 31) : 64'sd0,
                -1, 0, -1);
    end

    // Second strobe two clocks after the first is dropped.
    do_reset();
    run_frame("ovr", 1, 1, 1, 1, 4, -1, 0, 2);
    check_eq("ovr_cnt", ov_cnt, 64'sd1);
    load_delays(1, 1, 1, 1);
    run_frame("ovr_next", 7, 7, 7, 7, 4, -1, 0, -1);
    run_frame("ovr_next2", 0, 0, 0, 0, 28, -1, 0, -1);
    check_eq("ovr_cnt2", ov_cnt, 64'sd1);

    // Delay load during ACCUM takes effect from the next frame.
    do_reset();
    run_frame("ldacc", 1, 2, 3, 4, 10, 1, 1, -1);
    run_frame("ldacc_next", 10, 20, 30, 40, 10, -1, 0, -1);

    // Delay load coincident with the strobe: old delays for this frame.
    do_reset();
    run_frame("ldsim", 1, 2, 3, 4, 10, 0, 1, -1);
    run_frame("ldsim_next", 10, 20, 30, 40, 10, -1, 0, -1);

    // Reset pulsed mid-ACCUM aborts the frame and clears the history.
    do_reset();
    run_frame("pre", 9, 9, 9, 9, 36, -1, 0, -1);
    @(negedge clk_in);
    set_audio(6, 6, 6, 6);
    bus.audio_valid_in = 1'b1;
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in  = 1'b0;
    mid_vld = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (bus.sum_valid_out === 1'b1) mid_vld++;
    end
    check_eq("mid_nvld", mid_vld, 64'sd0);
    check_eq("mid_busy", bus.busy_out, 64'sd0);
    check_eq("mid_sum", bus.sum_out, 64'sd0);
    load_delays(1, 1, 1, 1);
    run_frame("post0", 5, 5, 5, 5, 0, -1, 0, -1);
    run_frame("post1", 0, 0, 0, 0, 20, -1, 0, -1);
    run_frame("post2", 0, 0, 0, 0, 0, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/delay_sum_beamformer.md
# delay_sum_beamformer

Delay-and-sum stage directly downstream of the TDM microphone receiver. It takes one frame of SLOTS signed samples per valid strobe and stores each channel in its own circular history buffer. It then sums, per channel, the sample from a programmable number of frames ago and emits one signed, full-precision beam sample per frame. Steering is applied by reloading the per-channel delays.

## Interface
- BIT_WIDTH, 24, sample width, signed two's complement
- SLOTS, 4, channel count; power of two, ≥2
- MAX_DELAY, 32, history depth per channel in frames; power of two
- DELAY_WIDTH, $clog2(MAX_DELAY), delay field width
- SUM_WIDTH, BIT_WIDTH+$clog2(SLOTS), output width

Ports:
- clk_in  input  1  100 MHz system clock
- rst_in  input  1  reset; asynchronous, active-high
- audio_in[SLOTS]  input  BIT_WIDTH  frame samples, signed; valid only with audio_valid_in
- audio_valid_in  input  1  one-cycle frame strobe
- delay_in[SLOTS]  input  DELAY_WIDTH  requested per-channel delay in frames
- delay_load_in  input  1  one-cycle request to load delay_in
- sum_out  output  SUM_WIDTH  signed beam sample
- sum_valid_out  output  1  one-cycle strobe qualifying sum_out
- overrun_out  output  1  one-cycle pulse: frame dropped
- busy_out  output  1  high whenever FSM ≠ IDLE

## Operation
- One clock domain (clk_in), with reset rst_in. Reset is asynchronous and active-high.
- While rst_in is asserted:
  - all history entries = 0, wr_ptr = 0, delays = 0, pending load cleared, FSM = IDLE;
  - sum_out = 0, sum_valid_out = 0, overrun_out = 0, busy_out = 0.
- FSM states: IDLE → ACCUM → DONE → IDLE.
- IDLE:
  - On audio_valid_in: write audio_in[i] to hist[i][wr_ptr] for all i in parallel.
  - Then set acc = 0, idx = 0, and go to ACCUM.
- ACCUM:
  - Each cycle: acc += sign-extend(hist[idx][(wr_ptr − delay[idx]) mod MAX_DELAY]), then idx++.
  - After idx = SLOTS−1, go to DONE.
- DONE:
  - sum_out ← acc, sum_valid_out ← 1, wr_ptr ← wr_ptr+1 (wraps MAX_DELAY−1→0).
  - Go to IDLE.
- Delay semantics:
  - d = 0 selects the sample from the current frame.
  - d = k selects the sample from k frames earlier.
  - Entries never written since reset read as 0.
- Arithmetic:
  - All operands are sign-extended to SUM_WIDTH; no saturation, no rounding.
  - SUM_WIDTH cannot overflow: SLOTS × (−2^(BIT_WIDTH−1)) fits exactly.
- Delay load:
  - delay_load_in in IDLE with no simultaneous audio_valid_in: delays ← delay_in at that edge.
  - Otherwise delay_in is captured into a pending register and applied on the first IDLE cycle.
  - A later request overwrites the pending values.
  - The delay set in use for a frame never changes mid-frame.
- Simultaneous delay_load_in and audio_valid_in in IDLE: the frame uses the OLD delays; the new delays apply from the next frame.
- Overrun: audio_valid_in while not IDLE → frame discarded (no write, no wr_ptr change) and overrun_out pulses one cycle. The in-flight frame completes unaffected.
- sum_out holds its value until the next DONE.

## Timing
- Edge 0 samples audio_valid_in high.
- Edges 1..SLOTS are ACCUM.
- Edge SLOTS+1 is DONE: sum_out and sum_valid_out are registered there. Latency is SLOTS+1 clocks (5 at default).
- sum_valid_out is high for exactly the one cycle after edge SLOTS+1.
- Minimum accepted frame spacing is SLOTS+2 clocks; a strobe at edges 1..SLOTS+1 is an overrun.
- busy_out is high from the cycle after edge 0 through the cycle after edge SLOTS+1.
- The receiver delivers frames about 2000 clocks apart, so overrun is a fault indicator only.
- History reads may be combinational or registered, provided the latency above is met exactly.
- Asserting rst_in mid-frame aborts immediately: no sum_valid_out, and all state is cleared.

## Test plan
- Reset, all delays 0, one frame {1, 2, 3, 4}:
  - sum_out = 10 with sum_valid_out exactly 5 clocks after the strobe;
  - overrun_out stays 0.
- Signed extremes, delays 0, frame {−8388608 ×4}:
  - sum_out = −33554432 (26-bit 0x2000000), with no wrap.
- Delays {0, 3, 0, 0}, impulse 100 on channel 1 in frame 0, zero frames after:
  - channel-1 contribution is 0 for frames 0–2;
  - sum_out = 100 at frame 3, then 0 again.
- Wrap-around, delay[0] = 31:
  - feed 40 frames with channel 0 = frame index, other channels 0;
  - frame n ≥ 31 yields sum_out = n−31 (frame 35 → 4);
  - frames < 31 yield 0.
- Overrun: a second strobe 2 clocks after the first:
  - overrun_out pulses once;
  - the first sum is correct;
  - the next legal frame uses the next wr_ptr, with no skipped entry.
- delay_load_in asserted during ACCUM with delay_in = {1, 1, 1, 1}:
  - the current frame uses the old delays;
  - the next frame uses delay 1.
- rst_in pulsed mid-ACCUM:
  - no sum_valid_out;
  - the following frame {5, 5, 5, 5} with delay 1 everywhere gives 0.
